// File: rtl/imem_loader_if.sv
// Byte stream in, word writes out: the handshake and memory-write bus of the program loader.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: header byte N, then 4*N bytes packed big-endian into word writes at 0,4,8,...
module imem_loader #(
  parameter int MEM_BYTES = 60
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_req,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          error
);
  localparam int unsigned MAX_WORDS = MEM_BYTES / 4;
  localparam int CW = ($clog2(MAX_WORDS + 1) < 4) ? 4 : $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {IDLE, HEADER, COLLECT, WRITE, DONE, ERROR} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  n_words, word_cnt;
  logic [1:0]     byte_cnt;
  logic [23:0]    asm_q;
  logic           wr_en_q;
  logic [31:0]    wr_addr_q, wr_data_q;
  logic           ready, take, hdr_ok, last_word;

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.in_ready = ready;

  always_comb begin
    ready      = (state == HEADER) || (state == COLLECT);
    busy       = (state == HEADER) || (state == COLLECT) || (state == WRITE);
    done       = (state == DONE);
    error      = (state == ERROR);
    take       = ready && bus.in_valid;
    hdr_ok     = (bus.in_data != 8'd0) && (32'(bus.in_data) <= MAX_WORDS);
    last_word  = ((word_cnt + CW'(1)) == n_words);
    state_next = state;
    case (state)
      IDLE:    if (load_req) state_next = HEADER;
      HEADER:  if (take) state_next = hdr_ok ? COLLECT : ERROR;
      COLLECT: if (take && byte_cnt == 2'd3) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : COLLECT;
      DONE:    if (load_req) state_next = HEADER;
      ERROR:   if (load_req) state_next = HEADER;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The write strobe and bus are registered on the edge that accepts the fourth byte,
  // so they are valid exactly for the WRITE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_words   <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        HEADER: begin
          if (take && hdr_ok) begin
            n_words  <= CW'(bus.in_data);
            word_cnt <= '0;
            byte_cnt <= '0;
          end
        end
        COLLECT: begin
          if (take) begin
            asm_q    <= {asm_q[15:0], bus.in_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= 32'(word_cnt) << 2;
              wr_data_q <= {asm_q, bus.in_data};
            end
          end
        end
        WRITE: begin
          word_cnt <= word_cnt + CW'(1);
          byte_cnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a byte-stream-to-word-list reference model.
module tb_imem_loader;
  localparam int unsigned MAX_WORDS = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_req = 1'b0;
  logic busy, done, error;

  imem_loader_if bus ();

  imem_loader #(.MEM_BYTES(60)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .bus(bus),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] obs_addr[$], obs_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_err;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      obs_addr.push_back(bus.wr_addr);
      obs_data.push_back(bus.wr_data);
    end
  end

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
  endtask

  // Reference: word i is bytes 1+4i..4+4i, first byte most significant, at byte address 4i.
  task automatic build_model(input logic [7:0] s[$]);
    int unsigned n = 32'(s[0]);
    exp_addr.delete();
    exp_data.delete();
    exp_err = (n == 0) || (n > MAX_WORDS);
    if (!exp_err)
      for (int unsigned i = 0; i < n; i++) begin
        exp_addr.push_back(4 * i);
        exp_data.push_back((32'(s[1+4*i]) << 24) | (32'(s[2+4*i]) << 16) |
                           (32'(s[3+4*i]) << 8)  |  32'(s[4+4*i]));
      end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned stall_pct, input logic req);
    int unsigned guard = 0;
    logic rdy = 1'b0;
    for (int k = 0; k < 3; k++)
      if ($urandom_range(99) < stall_pct) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    load_req     = req;
    do begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      load_req = 1'b0;
      guard++;
    end while (!rdy && guard < 50);
    bus.in_valid = 1'b0;
    if (!rdy) begin
      vectors++; miscompares++;
      $display("FAIL handshake_timeout: in_ready=%0b required 1", bus.in_ready);
    end
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic wait_end();
    int unsigned guard = 0;
    while (!done && !error && guard < 60) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!done && !error) begin
      vectors++; miscompares++;
      $display("FAIL end_timeout: done=%0b error=%0b required one of them 1", done, error);
    end
  endtask

  task automatic run_load(input logic [7:0] s[$], input int unsigned stall_pct, input int req_at);
    pulse_req();
    foreach (s[i]) send_byte(s[i], stall_pct, (i == req_at));
    wait_end();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    pulse_req();
    send_byte(8'd2, 0, 1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)), 0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({bus.in_ready, bus.wr_en, busy, done, error} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: ready/wr_en/busy/done/error=%b required 00000",
               {bus.in_ready, bus.wr_en, busy, done, error});
    end
    vectors++;
    if (bus.wr_addr !== 32'd0 || bus.wr_data !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_bus: wr_addr=%h wr_data=%h required 0 0", bus.wr_addr, bus.wr_data);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: in_ready=%b busy=%b required 0 0", bus.in_ready, busy);
    end
    clear_obs();
  endtask

  task automatic test_single_word();
    logic [7:0] s[$] = '{8'h01, 8'h20, 8'h09, 8'h00, 8'h0A};
    int unsigned idx = 0, cyc = 0;
    logic rdy;
    build_model(s);
    load_req = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = s[0];
    @(posedge clk); #1;
    load_req = 1'b0;
    while (!done && cyc < 20) begin
      rdy = bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      if (rdy && bus.in_valid) begin
        idx++;
        if (idx < 5) bus.in_data = s[idx];
        else         bus.in_valid = 1'b0;
      end
    end
    vectors++;
    if (cyc != 6) begin
      miscompares++;
      $display("FAIL single_latency: done after %0d cycles required 6", cyc);
    end
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 32'd0 || obs_data[0] !== 32'h2009000A ||
        obs_data[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL single_write: count=%0d addr=%h data=%h required 1 0 2009000a",
               obs_addr.size(), obs_addr.size() ? obs_addr[0] : 32'hx,
               obs_data.size() ? obs_data[0] : 32'hx);
    end
    clear_obs();
  endtask

  task automatic test_full_image();
    logic [7:0] s[$];
    s.push_back(8'd15);
    for (int i = 0; i < 60; i++) s.push_back(8'($urandom));
    build_model(s);
    run_load(s, 40, -1);
    vectors++;
    if (obs_addr.size() != 15) begin
      miscompares++;
      $display("FAIL full_count: writes=%0d required 15", obs_addr.size());
    end
    for (int i = 0; i < 15 && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL full_word%0d: addr=%h data=%h required %h %h",
                 i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
      miscompares++;
      $display("FAIL full_status: done=%b busy=%b error=%b required 1 0 0", done, busy, error);
    end
    clear_obs();
  endtask

  task automatic test_bad_header();
    logic [7:0] bad[2] = '{8'd0, 8'd16};
    logic [7:0] s[$];
    foreach (bad[b]) begin
      s.delete();
      s.push_back(bad[b]);
      build_model(s);
      run_load(s, 20, -1);
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (error !== exp_err || done !== 1'b0 || bus.in_ready !== 1'b0 || obs_addr.size() != 0) begin
        miscompares++;
        $display("FAIL bad_hdr_%0d: error=%b done=%b in_ready=%b writes=%0d required 1 0 0 0",
                 bad[b], error, done, bus.in_ready, obs_addr.size());
      end
    end
    s.delete();
    s.push_back(8'd2);
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
    build_model(s);
    run_load(s, 20, -1);
    vectors++;
    if (error !== 1'b0 || done !== 1'b1 || obs_addr.size() != 2) begin
      miscompares++;
      $display("FAIL recover: error=%b done=%b writes=%0d required 0 1 2", error, done, obs_addr.size());
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL recover_word%0d: addr=%h data=%h required %h %h",
                 i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    clear_obs();
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] s[$];
    s.push_back(8'd3);
    for (int i = 0; i < 12; i++) s.push_back(8'($urandom));
    build_model(s);
    pulse_req();
    for (int i = 0; i < 7; i++) send_byte(s[i], 30, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (obs_addr.size() != 1 || obs_addr[0] !== 32'd0 || obs_data[0] !== exp_data[0]) begin
      miscompares++;
      $display("FAIL midrst_writes: count=%0d data=%h required 1 %h",
               obs_addr.size(), obs_data.size() ? obs_data[0] : 32'hx, exp_data[0]);
    end
    vectors++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_idle: busy=%b in_ready=%b done=%b required 0 0 0", busy, bus.in_ready, done);
    end
    clear_obs();
  endtask

  task automatic test_ignored_req();
    logic [7:0] s[$];
    s.push_back(8'd2);
    for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
    build_model(s);
    run_load(s, 25, 3);
    vectors++;
    if (done !== 1'b1 || obs_addr.size() != 2) begin
      miscompares++;
      $display("FAIL ignreq_done: done=%b writes=%0d required 1 2", done, obs_addr.size());
    end
    for (int i = 0; i < 2 && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) begin
        miscompares++;
        $display("FAIL ignreq_word%0d: addr=%h data=%h required %h %h",
                 i, obs_addr[i], obs_data[i], exp_addr[i], exp_data[i]);
      end
    end
    pulse_req();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL restart: done=%b busy=%b in_ready=%b required 0 1 1", done, busy, bus.in_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    test_reset();
    test_single_word();
    test_full_image();
    test_bad_header();
    test_reset_mid_load();
    test_ignored_req();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
